// File: rtl/sparrow_pkg.sv
// rtl/sparrow_pkg.sv - shared constants and types for the sparrow core
package sparrow_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic {
        FETCH_RUN,
        FETCH_HALT
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } fetch_entry_t;

endpackage

// File: rtl/sparrow_fifo.sv
// rtl/sparrow_fifo.sv - generic synchronous FIFO with flush, power-of-two depth
module sparrow_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [31:0]
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    output T                           head,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] P_ONE   = AW'(1);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == C_DEPTH);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + P_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + P_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + C_ONE;
                2'b01:   count <= count - C_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sparrow_fetch.sv
// rtl/sparrow_fetch.sv - instruction fetch: PC, imem request credits, response buffer, redirect flush
module sparrow_fetch
    import sparrow_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_imem_rsp_err,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_fault,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [OW-1:0] O_ONE = OW'(1);
    localparam logic [OW-1:0] O_MAX = OW'(MAX_OUTSTANDING);

    fetch_state_e  state, state_next;
    logic [31:0]   fetch_pc, fetch_pc_next;
    logic [31:0]   rsp_pc, rsp_pc_next;
    logic [OW-1:0] outstanding, outstanding_next;
    logic [OW-1:0] drop_cnt, drop_cnt_next;
    logic [31:0]   redirect_target;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  push_entry, head_entry, out_entry;
    logic          req_fire, credit_ok;
    int            credit_used;

    assign redirect_target = i_redirect_pc & ~32'h3;
    assign fifo_pop        = !fifo_empty && i_instr_ready && !i_redirect;

    // outstanding counts every in-flight request, stale ones included, so a
    // slot freed by this cycle's pop can be reused without ever overflowing.
    always_comb begin
        credit_used = int'(outstanding) + int'(fifo_count) - (fifo_pop ? 1 : 0);
        credit_ok   = (credit_used < FIFO_DEPTH) && (outstanding < O_MAX)
                      && !(fifo_full && !fifo_pop);
    end

    assign o_imem_req_valid = i_rst_n && (state == FETCH_RUN) && !i_redirect && credit_ok;
    assign o_imem_req_addr  = fetch_pc;
    assign req_fire         = o_imem_req_valid && i_imem_req_ready;

    always_comb begin
        state_next       = state;
        fetch_pc_next    = fetch_pc;
        rsp_pc_next      = rsp_pc;
        drop_cnt_next    = drop_cnt;
        outstanding_next = outstanding;
        fifo_push        = 1'b0;
        push_entry       = '0;

        if (req_fire) begin
            outstanding_next = outstanding_next + O_ONE;
        end
        if (i_imem_rsp_valid) begin
            outstanding_next = outstanding_next - O_ONE;
        end

        if (i_redirect) begin
            state_next    = FETCH_RUN;
            fetch_pc_next = redirect_target;
            rsp_pc_next   = redirect_target;
            drop_cnt_next = outstanding - (i_imem_rsp_valid ? O_ONE : '0);
        end else begin
            if (req_fire) begin
                fetch_pc_next = fetch_pc + 32'd4;
            end
            if (i_imem_rsp_valid) begin
                if (drop_cnt != '0) begin
                    drop_cnt_next = drop_cnt - O_ONE;
                end else if (state == FETCH_RUN) begin
                    fifo_push   = 1'b1;
                    rsp_pc_next = rsp_pc + 32'd4;
                    if (i_imem_rsp_err) begin
                        push_entry = '{instr: RV_NOP, pc: rsp_pc, fault: 1'b1};
                        state_next = FETCH_HALT;
                    end else begin
                        push_entry = '{instr: i_imem_rsp_data, pc: rsp_pc, fault: 1'b0};
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= FETCH_RUN;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            rsp_pc      <= rsp_pc_next;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_cnt_next;
        end
    end

    sparrow_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head_entry),
        .flush     (i_redirect),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Stale storage never leaks out: an empty buffer presents all zeros.
    assign out_entry     = fifo_empty ? '0 : head_entry;
    assign o_instr_valid = !fifo_empty;
    assign o_instr       = out_entry.instr;
    assign o_instr_pc    = out_entry.pc;
    assign o_instr_fault = out_entry.fault;

endmodule
